// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;
  localparam int XLEN           = 32;
  localparam int CNT_W          = 4;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    DONE_IF,
    DONE_DM
  } arb_state_e;
endpackage

// File: rtl/mem_arb_lat_counter.sv
// Latency down-counter: loads on grant, counts down while an access is in flight.
module mem_arb_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// with data priority bounded by a starvation counter for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic            dm_byte,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ready,
  output logic            mem_en,
  output logic            mem_we,
  output logic            mem_byte,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output arb_state_e      dbg_state
);
  // Handshake: x_req is a level held until x_ready; x_ready is a single-cycle
  // completion pulse, and request inputs are only sampled while IDLE.
  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] SM_V  = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic             grant_if, grant_dm, busy;
  logic [CNT_W-1:0] starve_cnt, lat_cnt;
  logic             lat_zero;
  logic [XLEN-1:0]  lat_addr, lat_wdata;
  logic             lat_we, lat_byte;

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && (!dm_req || starve_cnt == SM_V)) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
        end else if (dm_req) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
        end
      end
      BUSY_IF: if (lat_zero) state_d = DONE_IF;
      BUSY_DM: if (lat_zero) state_d = DONE_DM;
      DONE_IF, DONE_DM: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

  mem_arb_lat_counter #(.W(CNT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_if || grant_dm),
    .dec      (busy),
    .load_val (LAT_V),
    .count    (lat_cnt),
    .zero     (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_byte   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_if) begin
        starve_cnt <= '0;
        lat_addr   <= if_addr;
        lat_wdata  <= '0;
        lat_we     <= 1'b0;
        lat_byte   <= 1'b0;
      end
      if (grant_dm) begin
        if (if_req && starve_cnt != SM_V) starve_cnt <= starve_cnt + CNT_W'(1);
        lat_addr  <= dm_addr;
        lat_wdata <= dm_wdata;
        lat_we    <= dm_we;
        lat_byte  <= dm_byte;
      end
      // Read data is valid in the final BUSY cycle; stores leave dm_rdata alone.
      if (state_q == BUSY_IF && lat_zero) if_rdata <= mem_rdata;
      if (state_q == BUSY_DM && lat_zero && !lat_we) dm_rdata <= mem_rdata;
    end
  end

  assign mem_en    = busy && (lat_cnt == LAT_V);
  assign mem_we    = busy && lat_we;
  assign mem_byte  = busy && lat_byte;
  assign mem_addr  = busy ? lat_addr : '0;
  assign mem_wdata = busy ? lat_wdata : '0;

  assign if_ready  = (state_q == DONE_IF);
  assign dm_ready  = (state_q == DONE_DM);
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a transaction-timed
// reference model with a behavioural memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, dm_byte;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, mem_byte, stall_if, stall_mem;
  arb_state_e  dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  // Behavioural memory seen by the DUT, and the model's own copy.
  logic [31:0] tb_mem [128];
  logic [31:0] ref_mem[128];
  bit          rd_valid;
  int          rd_cyc;
  logic [6:0]  rd_idx;

  // Reference model: one access in flight, described by its grant cycle.
  bit          m_busy, m_dm, m_we, m_byte;
  int          m_grant, m_starve;
  logic [31:0] m_addr, m_wdata, m_data, e_if_rdata, e_dm_rdata;
  bit          last_ifr, last_dmr;

  // Observation log for directed timing checks.
  int          t0, en_cnt, en_cyc, ifr_cnt, ifr_cyc, ifr_first, dmr_cnt, dmr_cyc;
  logic [31:0] en_addr;
  logic        en_we, en_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic b);
    logic [31:0] r;
    r = old;
    if (!b) return d;
    r[a[1:0]*8 +: 8] = d[7:0];
    return r;
  endfunction

  // Runs one clock cycle: inputs for cycle t are already applied by the caller.
  task automatic cycle();
    bit bph, dn_now, e_ifr, e_dmr, pick_if, pick_dm;
    mem_rdata = (rd_valid && t == rd_cyc) ? tb_mem[rd_idx] : $urandom();
    @(negedge clk);
    bph    = m_busy && t >= m_grant + 1 && t <= m_grant + LAT + 1;
    dn_now = m_busy && t == m_grant + LAT + 2;
    e_ifr  = dn_now && !m_dm;
    e_dmr  = dn_now && m_dm;
    if (e_ifr) e_if_rdata = m_data;
    if (e_dmr && !m_we) e_dm_rdata = m_data;

    check("mem_en",    32'(mem_en),    32'(m_busy && t == m_grant + 1));
    check("mem_we",    32'(mem_we),    32'(bph && m_we));
    check("mem_byte",  32'(mem_byte),  32'(bph && m_byte));
    check("mem_addr",  mem_addr,       bph ? m_addr : 32'h0);
    check("mem_wdata", mem_wdata,      bph ? m_wdata : 32'h0);
    check("if_ready",  32'(if_ready),  32'(e_ifr));
    check("dm_ready",  32'(dm_ready),  32'(e_dmr));
    check("if_rdata",  if_rdata,       e_if_rdata);
    check("dm_rdata",  dm_rdata,       e_dm_rdata);
    check("stall_if",  32'(stall_if),  32'(if_req && !e_ifr));
    check("stall_mem", 32'(stall_mem), 32'(dm_req && !e_dmr));

    if (mem_en) begin
      en_cnt++; en_cyc = t; en_addr = mem_addr; en_we = mem_we; en_byte = mem_byte;
      rd_valid = 1'b1; rd_cyc = t + LAT; rd_idx = mem_addr[8:2];
      if (mem_we) tb_mem[mem_addr[8:2]] = merge(tb_mem[mem_addr[8:2]], mem_addr, mem_wdata, mem_byte);
    end
    if (if_ready) begin
      ifr_cnt++; ifr_cyc = t;
      if (ifr_cnt == 1) ifr_first = t;
    end
    if (dm_ready) begin dmr_cnt++; dmr_cyc = t; end

    if (rst) begin
      m_busy = 0; m_starve = 0; e_if_rdata = '0; e_dm_rdata = '0;
    end else if (dn_now) begin
      m_busy = 0;
    end else if (!m_busy) begin
      pick_if = if_req && (!dm_req || m_starve == SMAX);
      pick_dm = dm_req && !pick_if;
      if (pick_if) begin
        m_busy = 1; m_dm = 0; m_grant = t; m_starve = 0;
        m_addr = if_addr; m_we = 0; m_byte = 0; m_wdata = '0;
        m_data = ref_mem[if_addr[8:2]];
      end else if (pick_dm) begin
        m_busy = 1; m_dm = 1; m_grant = t;
        if (if_req && m_starve < SMAX) m_starve++;
        m_addr = dm_addr; m_we = dm_we; m_byte = dm_byte; m_wdata = dm_wdata;
        if (dm_we) ref_mem[dm_addr[8:2]] = merge(ref_mem[dm_addr[8:2]], dm_addr, dm_wdata, dm_byte);
        else m_data = ref_mem[dm_addr[8:2]];
      end
    end
    last_ifr = e_ifr;
    last_dmr = e_dmr;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; dm_byte = 0; rst = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    idle_inputs();
    while (m_busy && n < 40) begin cycle(); n++; end
  endtask

  task automatic mark();
    t0 = t; en_cnt = 0; ifr_cnt = 0; dmr_cnt = 0;
    en_cyc = -1; ifr_cyc = -1; ifr_first = -1; dmr_cyc = -1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      tb_mem[i] = $urandom(); ref_mem[i] = tb_mem[i];
    end
    tb_mem[80] = 32'h8C130004; ref_mem[80] = 32'h8C130004;
    tb_mem[8]  = 32'h0000000F; ref_mem[8]  = 32'h0000000F;
    tb_mem[12] = 32'h33333333; ref_mem[12] = 32'h33333333;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(dbg_state), 32'(IDLE));
    cycle();
    rst = 0;

    // Single fetch: mem_en in cycle 1, ready in cycle 4.
    mark();
    if_req = 1; if_addr = 32'h140;
    for (int k = 0; k < 6; k++) begin cycle(); if (k == 4) if_req = 0; end
    check("fetch mem_en count", 32'(en_cnt), 32'd1);
    check("fetch mem_en cycle", 32'(en_cyc - t0), 32'd1);
    check("fetch ready cycle", 32'(ifr_cyc - t0), 32'd4);
    check("fetch rdata", if_rdata, 32'h8C130004);

    // Simultaneous requests: data first, then fetch.
    wait_idle(); mark();
    if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k == 4) dm_req = 0;
      if (k == 9) if_req = 0;
    end
    check("both dm ready cycle", 32'(dmr_cyc - t0), 32'd4);
    check("both if ready cycle", 32'(ifr_cyc - t0), 32'd9);
    check("both dm rdata", dm_rdata, 32'h0000000F);

    // Starvation bound: three data grants, then fetch, twice over.
    wait_idle(); mark();
    dm_req = 1; dm_addr = 32'h20; if_req = 1; if_addr = 32'h140;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (k == 34) dm_req = 0;
      if (k == 39) if_req = 0;
    end
    check("starve first if ready", 32'(ifr_first - t0), 32'd19);
    check("starve second if ready", 32'(ifr_cyc - t0), 32'd39);
    check("starve if count", 32'(ifr_cnt), 32'd2);
    check("starve dm count", 32'(dmr_cnt), 32'd6);

    // Byte store leaves dm_rdata untouched.
    wait_idle(); mark();
    dm_req = 1; dm_we = 1; dm_byte = 1; dm_addr = 32'h44; dm_wdata = 32'hAB;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 4) begin dm_req = 0; dm_we = 0; dm_byte = 0; end
    end
    check("store mem_en cycle", 32'(en_cyc - t0), 32'd1);
    check("store mem_we", 32'(en_we), 32'd1);
    check("store mem_byte", 32'(en_byte), 32'd1);
    check("store mem_addr", en_addr, 32'h44);
    check("store ready cycle", 32'(dmr_cyc - t0), 32'd4);
    check("store dm_rdata held", dm_rdata, 32'h0000000F);

    // Reset in cycle 2 of a fetch, then a fresh fetch right after.
    wait_idle(); mark();
    if_req = 1; if_addr = 32'h140;
    for (int k = 0; k < 9; k++) begin
      rst = (k == 2);
      if (k == 3) if_addr = 32'h80;
      cycle();
      if (k == 7) if_req = 0;
    end
    rst = 0;
    check("reset ready count", 32'(ifr_cnt), 32'd1);
    check("reset refetch ready", 32'(ifr_cyc - t0), 32'd7);
    check("reset mem_en count", 32'(en_cnt), 32'd2);
    check("reset refetch addr", en_addr, 32'h80);

    // Address change during BUSY_DM is ignored.
    wait_idle(); mark();
    dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 0) dm_addr = 32'h30;
      if (k == 4) dm_req = 0;
    end
    check("addr hold mem_addr", en_addr, 32'h20);
    check("addr hold rdata", dm_rdata, 32'h0000000F);
    check("addr hold ready cycle", 32'(dmr_cyc - t0), 32'd4);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!if_req || last_ifr) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom_range(0, 511);
      end else if (m_busy && !m_dm) begin
        if_addr = $urandom();
      end
      if (!dm_req || last_dmr) begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_addr = $urandom_range(0, 511);
        dm_we = $urandom_range(0, 1);
        dm_byte = $urandom_range(0, 1);
        dm_wdata = $urandom();
      end else if (m_busy && m_dm) begin
        dm_addr = $urandom(); dm_wdata = $urandom();
        dm_we = $urandom_range(0, 1); dm_byte = $urandom_range(0, 1);
      end
      cycle();
    end

    wait_idle();
    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
